// File: rtl/aesl_deadlock_pkg.sv
// Shared definitions for the dataflow deadlock monitor: state encoding,
// stream-ownership slice and lowest-set-bit encoder.
package aesl_deadlock_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_BLOCKED = 2'd2;

  // True when any stream owned by process 'proc' reports a stall.
  function automatic logic axis_owned_hit(input logic [1023:0] map,
                                          input logic [31:0]   sigs,
                                          input int            proc,
                                          input int            num_axis);
    logic [1023:0] shifted;
    logic [31:0]   mask;
    shifted = map >> (proc * num_axis);
    mask    = (num_axis >= 32) ? 32'hffff_ffff : ((32'd1 << num_axis) - 32'd1);
    return |(sigs & shifted[31:0] & mask);
  endfunction

  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/aesl_deadlock_persist_ctr.sv
// Persistence counter: counts consecutive qualifying cycles, saturates at
// THRESH-1 and restarts on clr.
module aesl_deadlock_persist_ctr #(
  parameter int CNT_W  = 16,
  parameter int THRESH = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(THRESH - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == TC);

endmodule

// File: rtl/aesl_deadlock_param_monitor.sv
// Deadlock monitor for one dataflow region. Optional cycle trace is enabled
// with the DEADLOCK_MONITOR_TRACE_EN macro.
//
// state   | meaning
// RUN     | no stall pattern seen, counter idle
// SUSPECT | stall pattern held, counting towards THRESH
// BLOCKED | deadlock reported, block_idx frozen
module aesl_deadlock_param_monitor
  import aesl_deadlock_pkg::*;
#(
  parameter int                          NUM_PROC = 4,
  parameter int                          NUM_AXIS = 2,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP = '1,
  parameter int                          THRESH   = 1,
  parameter bit                          STICKY   = 1'b0,
  parameter int                          IDX_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1,
  parameter int                          CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_PROC-1:0] child_block,
  input  logic                clear,
`ifdef DEADLOCK_MONITOR_TRACE_EN
  output logic [31:0]         trace_cycle,
`endif
  output logic                block,
  output logic [IDX_W-1:0]    block_idx,
  output logic                block_idx_valid
);

  if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
    $error("THRESH out of range for CNT_W");
  end

  logic [NUM_PROC-1:0] axis_blk;
  logic [NUM_PROC-1:0] stop;
  logic                cond;
  logic                hit;
  logic [1:0]          state;
  logic [1:0]          nxt;
  logic                enter_blk;

  for (genvar i = 0; i < NUM_PROC; i++) begin : g_proc
    assign axis_blk[i] = child_block[i] &
                         axis_owned_hit(1024'(AXIS_MAP), 32'(axis_block_sigs), i, NUM_AXIS);
  end

  assign stop = inst_idle_sigs | inst_block_sigs | axis_blk;
  assign cond = (|axis_blk) & (&stop);

  aesl_deadlock_persist_ctr #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_persist (
    .clock (clock),
    .reset (reset),
    .clr   (clear | ~cond | (state == ST_BLOCKED)),
    .inc   (cond),
    .hit   (hit)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_RUN: begin
        if (cond) nxt = (THRESH == 1) ? ST_BLOCKED : ST_SUSPECT;
      end
      ST_SUSPECT: begin
        if (!cond)    nxt = ST_RUN;
        else if (hit) nxt = ST_BLOCKED;
      end
      ST_BLOCKED: begin
        if (!STICKY && !cond) nxt = ST_RUN;
      end
      default: nxt = ST_RUN;
    endcase
    if (clear) nxt = ST_RUN;
  end

  assign enter_blk = (nxt == ST_BLOCKED) && (state != ST_BLOCKED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_RUN;
      block           <= 1'b0;
      block_idx       <= '0;
      block_idx_valid <= 1'b0;
    end else begin
      state           <= nxt;
      block           <= (nxt == ST_BLOCKED);
      block_idx_valid <= (nxt == ST_BLOCKED);
      if (enter_blk) block_idx <= IDX_W'(lowest_set(32'(axis_blk)));
    end
  end

`ifdef DEADLOCK_MONITOR_TRACE_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      trace_cycle <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (enter_blk) begin
        trace_cycle <= cycle_cnt;
        $display("deadlock: cycle %0d idx %0d axis %b idle %b chan %b", cycle_cnt,
                 lowest_set(32'(axis_blk)), axis_block_sigs, inst_idle_sigs, inst_block_sigs);
      end
    end
  end
`endif

endmodule
